vga_frame_ctrl: RTL and testbench

Frame-level VGA controller for the 640x480@60 display path. It divides the system clock into a pixel enable and sequences the horizontal and vertical timing counters. It generates hsync, vsync and display_time. It also arbitrates the single-port 128x96 frame-buffer RAM (5x5 pixel scaling) between display fetches and a host write port.

---
 rtl/vga_timing_pkg.sv | 41 ++++
 rtl/vga_frame_ctrl_if.sv | 31 +++
 rtl/vga_axis_counter.sv | 62 ++++++
 rtl/vga_frame_ctrl.sv | 92 +++++++++
 tb/tb_vga_frame_ctrl.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Timing constants, widths and derivation helpers for the VGA frame controller.
package vga_timing_pkg;

    typedef struct packed {
        int active;
        int fp;
        int sync;
        int bp;
    } axis_timing_t;

    localparam axis_timing_t H_TIMING = '{active: 640, fp: 16, sync: 96, bp: 48};
    localparam axis_timing_t V_TIMING = '{active: 480, fp: 10, sync: 2, bp: 33};

    localparam int PIX_DIV = 4;
    localparam int SCALE   = 5;
    localparam int ADDR_W  = 14;
    localparam int DATA_W  = 3;
    localparam int IDX_W   = ADDR_W / 2;
    localparam int CNT_W   = 10;
    localparam int SUB_W   = $clog2(SCALE);
    localparam int PH_W    = $clog2(PIX_DIV);

    typedef logic [ADDR_W-1:0] fb_addr_t;
    typedef logic [DATA_W-1:0] pixel_t;

    function automatic int axis_total(input axis_timing_t t);
        return t.active + t.fp + t.sync + t.bp;
    endfunction

    function automatic int sync_first(input axis_timing_t t);
        return t.active + t.fp;
    endfunction

    function automatic int sync_last(input axis_timing_t t);
        return t.active + t.fp + t.sync - 1;
    endfunction

    localparam int H_TOTAL = axis_total(H_TIMING);
    localparam int V_TOTAL = axis_total(V_TIMING);

endpackage

// File: rtl/vga_frame_ctrl_if.sv
// Video, frame-buffer and host-write signals of the VGA frame controller.
interface vga_frame_ctrl_if;
    import vga_timing_pkg::*;

    logic     hsync;
    logic     vsync;
    logic     display_time;
    logic     frame_start;
    pixel_t   rgb;
    fb_addr_t mem_addr;
    logic     mem_we;
    pixel_t   mem_wdata;
    pixel_t   mem_rdata;
    logic     wr_req;
    fb_addr_t wr_addr;
    pixel_t   wr_data;
    logic     wr_ack;

    modport master (
        output hsync, vsync, display_time, frame_start, rgb,
        output mem_addr, mem_we, mem_wdata, wr_ack,
        input  mem_rdata, wr_req, wr_addr, wr_data
    );

    modport slave (
        input  hsync, vsync, display_time, frame_start, rgb,
        input  mem_addr, mem_we, mem_wdata, wr_ack,
        output mem_rdata, wr_req, wr_addr, wr_data
    );

endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis: position counter with wrap pulse, plus a scaled frame-buffer
// index that advances once per SCALE positions inside the active region.
module vga_axis_counter
    import vga_timing_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic [CNT_W-1:0] term_i,
    input  logic [CNT_W-1:0] active_i,
    output logic [CNT_W-1:0] pos_o,
    output logic             wrap_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [CNT_W-1:0] pos_q, pos_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [SUB_W-1:0] sub_q, sub_d;
    logic             wrap;

    assign wrap = en_i && (pos_q == term_i);

    always_comb begin
        // NOTE: defaults first so every path assigns every signal; no latch is inferred.
        pos_d = pos_q;
        idx_d = idx_q;
        sub_d = sub_q;
        if (wrap) begin
            pos_d = '0;
            idx_d = '0;
            sub_d = '0;
        end else if (en_i) begin
            pos_d = pos_q + CNT_W'(1);
            if (pos_q < active_i) begin
                if (sub_q == SUB_W'(SCALE - 1)) begin
                    sub_d = '0;
                    idx_d = idx_q + IDX_W'(1);
                end else begin
                    sub_d = sub_q + SUB_W'(1);
                end
            end
        end
    end

    // NOTE: registers use <= so every flop samples the pre-edge values of its peers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pos_q <= '0;
            idx_q <= '0;
            sub_q <= '0;
        end else begin
            pos_q <= pos_d;
            idx_q <= idx_d;
            sub_q <= sub_d;
        end
    end

    assign pos_o  = pos_q;
    assign wrap_o = wrap;
    assign idx_o  = idx_q;

endmodule

// File: rtl/vga_frame_ctrl.sv
// 640x480 VGA timing generator with 5x-scaled frame-buffer fetch and a host
// write port that is granted every clock except the display fetch slot.
module vga_frame_ctrl
    import vga_timing_pkg::*;
#(
    parameter axis_timing_t H_T = H_TIMING,
    parameter axis_timing_t V_T = V_TIMING
) (
    input  logic              clk,
    input  logic              reset,
    vga_frame_ctrl_if.master  bus
);

    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(PIX_DIV - 1);
    localparam logic [CNT_W-1:0] H_TERM   = CNT_W'(axis_total(H_T) - 1);
    localparam logic [CNT_W-1:0] V_TERM   = CNT_W'(axis_total(V_T) - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_T.active);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_T.active);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(sync_first(H_T));
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(sync_last(H_T));
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(sync_first(V_T));
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(sync_last(V_T));

    logic [PH_W-1:0]  ph_q, ph_d;
    logic             fetch_valid_q, fetch_valid_d;
    pixel_t           rgb_q, rgb_d;
    logic             pix_en, h_wrap, v_wrap;
    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic [IDX_W-1:0] hpix, vpix;
    logic             display_time, fetch_slot, grant;

    assign pix_en = (ph_q == PH_LAST);

    vga_axis_counter u_h_axis (
        .clk      (clk),
        .reset    (reset),
        .en_i     (pix_en),
        .term_i   (H_TERM),
        .active_i (H_ACT),
        .pos_o    (h_cnt),
        .wrap_o   (h_wrap),
        .idx_o    (hpix)
    );

    vga_axis_counter u_v_axis (
        .clk      (clk),
        .reset    (reset),
        .en_i     (h_wrap),
        .term_i   (V_TERM),
        .active_i (V_ACT),
        .pos_o    (v_cnt),
        .wrap_o   (v_wrap),
        .idx_o    (vpix)
    );

    assign display_time = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign fetch_slot   = (ph_q == '0) && display_time;
    // Display owns the RAM in its fetch slot; a write held there is granted one clk later.
    assign grant        = bus.wr_req && !fetch_slot && !reset;

    always_comb begin
        ph_d          = (ph_q == PH_LAST) ? '0 : ph_q + PH_W'(1);
        fetch_valid_d = fetch_slot;
        rgb_d         = rgb_q;
        if (ph_q == PH_W'(1)) begin
            rgb_d = fetch_valid_q ? bus.mem_rdata : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ph_q          <= '0;
            fetch_valid_q <= 1'b0;
            rgb_q         <= '0;
        end else begin
            ph_q          <= ph_d;
            fetch_valid_q <= fetch_valid_d;
            rgb_q         <= rgb_d;
        end
    end

    assign bus.hsync        = !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
    assign bus.vsync        = !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));
    assign bus.display_time = display_time;
    assign bus.frame_start  = v_wrap;
    assign bus.rgb          = rgb_q;
    assign bus.wr_ack       = grant;
    assign bus.mem_we       = grant;
    assign bus.mem_addr     = grant ? bus.wr_addr : {vpix, hpix};
    assign bus.mem_wdata    = grant ? bus.wr_data : '0;

endmodule

// File: tb/tb_vga_frame_ctrl.sv
// Directed bench for vga_frame_ctrl: line/frame timing (16-line frame), scaled
// fetch and rgb timing, write arbitration and mid-frame reset.
module tb_vga_frame_ctrl;
    import vga_timing_pkg::*;

    localparam axis_timing_t TB_V = '{active: 10, fp: 2, sync: 2, bp: 2};
    localparam int LINE = 3200;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;

    vga_frame_ctrl_if bus();

    vga_frame_ctrl #(.V_T(TB_V)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Frame-buffer RAM model: one-clk read latency, preloaded while reset is high.
    pixel_t mem [0:(1 << ADDR_W) - 1];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < (1 << ADDR_W); i++) mem[i] <= '0;
            mem[129] <= 3'b101;
            bus.mem_rdata <= '0;
        end else begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    logic mon_en = 1'b0;
    logic hs_prev = 1'b1;
    logic dt_prev = 1'b1;
    int   hs_fall0 = -1, hs_fall1 = -1, hs_rise0 = -1, dt_fall0 = -1;
    int   vs_first = -1, vs_low = 0, fs_first = -1, fs_count = 0;

    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (hs_prev && !bus.hsync) begin
                if (hs_fall0 < 0)      hs_fall0 <= cyc;
                else if (hs_fall1 < 0) hs_fall1 <= cyc;
            end
            if (!hs_prev && bus.hsync && hs_rise0 < 0) hs_rise0 <= cyc;
            if (dt_prev && !bus.display_time && dt_fall0 < 0) dt_fall0 <= cyc;
            if (!bus.vsync) begin
                vs_low <= vs_low + 1;
                if (vs_first < 0) vs_first <= cyc;
            end
            if (bus.frame_start) begin
                fs_count <= fs_count + 1;
                if (fs_first < 0) fs_first <= cyc;
            end
            hs_prev <= bus.hsync;
            dt_prev <= bus.display_time;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) @(negedge clk);
        if (cyc != c) check("goto", cyc, c);
    endtask

    function automatic int l5_rgb(input int h);
        return (h >= 5 && h <= 9) ? 5 : 0;
    endfunction

    int     addr_i;
    pixel_t data_i;

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.wr_req = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_hsync", bus.hsync, 1);
        check("rst_vsync", bus.vsync, 1);
        check("rst_disp", bus.display_time, 1);
        check("rst_fs", bus.frame_start, 0);
        check("rst_rgb", bus.rgb, 0);
        check("rst_we", bus.mem_we, 0);
        check("rst_ack", bus.wr_ack, 0);
        check("rst_addr", bus.mem_addr, 0);
        reset = 1'b0;
        mon_en = 1'b1;

        // Write colliding with a fetch slot (v=2, h=10, ph=0)
        goto(2*LINE + 40);
        bus.wr_req = 1'b1;
        bus.wr_addr = 14'd200;
        bus.wr_data = 3'b011;
        #1;
        check("col_ack", bus.wr_ack, 0);
        check("col_we", bus.mem_we, 0);
        check("col_addr", bus.mem_addr, 2);
        goto(2*LINE + 41);
        check("late_ack", bus.wr_ack, 1);
        check("late_we", bus.mem_we, 1);
        check("late_addr", bus.mem_addr, 200);
        check("late_data", bus.mem_wdata, 3);
        @(posedge clk);
        #1 bus.wr_req = 1'b0;

        // Fetch address and rgb around the preloaded word
        goto(4*LINE + 28);
        check("l4_addr", bus.mem_addr, 1);
        check("l4_we", bus.mem_we, 0);
        goto(4*LINE + 30);
        check("l4_rgb", bus.rgb, 0);
        for (int h = 3; h <= 11; h++) begin
            goto(5*LINE + 4*h + 1);
            check($sformatf("l5_h%0d_ph1", h), bus.rgb, l5_rgb(h - 1));
            goto(5*LINE + 4*h + 2);
            check($sformatf("l5_h%0d_ph2", h), bus.rgb, l5_rgb(h));
        end
        goto(5*LINE + 4*359 + 2);
        check("l5_h359", bus.rgb, 0);
        goto(5*LINE + 4*360 + 2);
        check("l5_h360_written", bus.rgb, 3);
        goto(6*LINE + 28);
        check("l6_addr", bus.mem_addr, 129);
        goto(9*LINE + 4*9 + 2);
        check("l9_h9", bus.rgb, 5);
        goto(9*LINE + 4*10 + 2);
        check("l9_h10", bus.rgb, 0);
        goto(10*LINE + 30);
        check("l10_rgb", bus.rgb, 0);
        check("l10_disp", bus.display_time, 0);

        // Continuous writes in vertical blanking
        for (int i = 0; i < 16; i++) begin
            goto(33000 + i);
            addr_i = (i == 0) ? 60 : 1000 + i;
            data_i = (i == 0) ? 3'd6 : 3'(i);
            bus.wr_req = 1'b1;
            bus.wr_addr = 14'(addr_i);
            bus.wr_data = data_i;
            #1;
            check($sformatf("vb%0d_ack", i), bus.wr_ack, 1);
            check($sformatf("vb%0d_we", i), bus.mem_we, 1);
            check($sformatf("vb%0d_addr", i), bus.mem_addr, addr_i);
            check($sformatf("vb%0d_data", i), bus.mem_wdata, data_i);
        end
        @(posedge clk);
        #1 bus.wr_req = 1'b0;

        // Frame-level timing gathered by the monitor
        goto(16*LINE + 10);
        mon_en = 1'b0;
        check("hs_fall", hs_fall0, 2624);
        check("hs_rise", hs_rise0, 3008);
        check("hs_fall_line1", hs_fall1, 2624 + LINE);
        check("disp_fall", dt_fall0, 2560);
        check("vs_start", vs_first, 12*LINE);
        check("vs_len", vs_low, 2*LINE);
        check("fs_at", fs_first, 16*LINE - 1);
        check("fs_count", fs_count, 1);

        // Reset at h=300, v=1 with a grantable write pending
        goto(17*LINE + 1202);
        check("pre_rst_rgb", bus.rgb, 6);
        bus.wr_req = 1'b1;
        bus.wr_addr = 14'd5;
        bus.wr_data = 3'd7;
        reset = 1'b1;
        #1;
        check("in_rst_ack", bus.wr_ack, 0);
        check("in_rst_we", bus.mem_we, 0);
        @(posedge clk);
        @(negedge clk);
        check("post_rgb", bus.rgb, 0);
        check("post_ack", bus.wr_ack, 0);
        check("post_we", bus.mem_we, 0);
        check("post_hsync", bus.hsync, 1);
        check("post_vsync", bus.vsync, 1);
        check("post_addr", bus.mem_addr, 0);
        reset = 1'b0;
        goto(1);
        check("post_ack1", bus.wr_ack, 1);
        check("post_addr1", bus.mem_addr, 5);
        @(posedge clk);
        #1 bus.wr_req = 1'b0;
        goto(2623);
        check("post_hs_hi", bus.hsync, 1);
        goto(2624);
        check("post_hs_lo", bus.hsync, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
